// File: rtl/keypad_matrix_scanner.sv
// 4x4 key matrix scanner: drives one column low at a time, samples the rows,
// debounces whole sweeps and hands single key presses to the core via valid/ready.
module keypad_matrix_scanner #(
  parameter int CLK_FREQ_HZ    = 27000000,
  parameter int SCAN_FREQ_HZ   = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col_drive_n,
  input  logic [3:0] row_in_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun
);

  localparam int              DIV      = CLK_FREQ_HZ / SCAN_FREQ_HZ;
  localparam int              CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   DIV_LAST = CW'(DIV - 1);
  localparam logic [3:0]      DEB_N    = 4'(DEBOUNCE_SCANS);

  generate
    if (DIV < 4) begin : g_bad_div
      $error("keypad_matrix_scanner: column period DIV must be at least 4 cycles");
    end
    if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_deb
      $error("keypad_matrix_scanner: DEBOUNCE_SCANS must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEB_PRESS,
    S_PRESSED,
    S_DEB_RELEASE
  } state_t;

  logic [3:0]    r_row_meta;
  logic [3:0]    r_row_sync;
  logic [CW-1:0] r_div_cnt;
  logic [1:0]    r_col;
  logic [3:0]    r_col_drive_n;
  logic [15:0]   r_snap;
  logic          r_sweep_done;

  state_t        r_state;
  logic [3:0]    r_cand;
  logic [3:0]    r_deb_cnt;
  logic          r_press_evt;
  logic          r_key_held;
  logic [3:0]    r_key_code;
  logic          r_key_valid;
  logic          r_overrun;

  logic [3:0]    w_rows;
  logic [15:0]   w_snap_next;
  logic [4:0]    w_bit_cnt;
  logic [3:0]    w_single_idx;
  logic          w_none;
  logic          w_single;

  assign w_rows = ~r_row_sync;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_snap_next = r_snap;
    for (int r = 0; r < 4; r++) begin
      w_snap_next[{2'(r), r_col}] = w_rows[r];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; all registers, including the
  // synchronizer and snapshot, are reset so a mid-operation rst leaves no stale progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_meta    <= 4'hF;
      r_row_sync    <= 4'hF;
      r_div_cnt     <= '0;
      r_col         <= 2'd0;
      r_col_drive_n <= 4'b1110;
      r_snap        <= '0;
      r_sweep_done  <= 1'b0;
    end else begin
      r_row_meta   <= row_in_n;
      r_row_sync   <= r_row_meta;
      r_sweep_done <= 1'b0;
      if (r_div_cnt == DIV_LAST) begin
        r_div_cnt     <= '0;
        r_snap        <= w_snap_next;
        r_col         <= r_col + 2'd1;
        r_col_drive_n <= ~(4'b0001 << (r_col + 2'd1));
        r_sweep_done  <= (r_col == 2'd3);
      end else begin
        r_div_cnt <= r_div_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    w_bit_cnt    = '0;
    w_single_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (r_snap[i]) begin
        w_bit_cnt    = w_bit_cnt + 5'd1;
        w_single_idx = 4'(i);
      end
    end
    w_none   = (w_bit_cnt == 5'd0);
    w_single = (w_bit_cnt == 5'd1);
  end

  // Sweep classification drives the debounce FSM; r_press_evt delays the event load by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cand      <= '0;
      r_deb_cnt   <= '0;
      r_press_evt <= 1'b0;
      r_key_held  <= 1'b0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_press_evt <= 1'b0;
      if (r_sweep_done) begin
        unique case (r_state)
          S_IDLE: begin
            if (w_single) begin
              r_cand    <= w_single_idx;
              r_deb_cnt <= 4'd1;
              if (DEB_N == 4'd1) begin
                r_state     <= S_PRESSED;
                r_press_evt <= 1'b1;
                r_key_held  <= 1'b1;
              end else begin
                r_state <= S_DEB_PRESS;
              end
            end
          end
          S_DEB_PRESS: begin
            if (w_single && (w_single_idx == r_cand)) begin
              r_deb_cnt <= r_deb_cnt + 4'd1;
              if (r_deb_cnt + 4'd1 == DEB_N) begin
                r_state     <= S_PRESSED;
                r_press_evt <= 1'b1;
                r_key_held  <= 1'b1;
              end
            end else if (w_single) begin
              r_cand    <= w_single_idx;
              r_deb_cnt <= 4'd1;
            end else begin
              r_state   <= S_IDLE;
              r_deb_cnt <= 4'd0;
            end
          end
          S_PRESSED: begin
            if (w_none) begin
              r_deb_cnt <= 4'd1;
              if (DEB_N == 4'd1) begin
                r_state    <= S_IDLE;
                r_key_held <= 1'b0;
              end else begin
                r_state <= S_DEB_RELEASE;
              end
            end
          end
          S_DEB_RELEASE: begin
            if (w_none) begin
              r_deb_cnt <= r_deb_cnt + 4'd1;
              if (r_deb_cnt + 4'd1 == DEB_N) begin
                r_state    <= S_IDLE;
                r_key_held <= 1'b0;
              end
            end else begin
              // Release bounce returns to the held key without a second event.
              r_state <= S_PRESSED;
            end
          end
        endcase
      end

      if (r_press_evt) begin
        if (!r_key_valid || key_ready) begin
          r_key_code  <= r_cand;
          r_key_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_key_valid && key_ready) begin
        r_key_valid <= 1'b0;
      end
    end
  end

  assign col_drive_n = r_col_drive_n;
  assign key_code    = r_key_code;
  assign key_valid   = r_key_valid;
  assign key_held    = r_key_held;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench for keypad_matrix_scanner: a keypad model closes row/column contacts,
// a scoreboard queue holds the key codes expected at each valid/ready handshake.
module tb_keypad_matrix_scanner;

  localparam int CLK_FREQ_HZ    = 64;
  localparam int SCAN_FREQ_HZ   = 4;
  localparam int DEBOUNCE_SCANS = 3;
  localparam int SWEEP          = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_ready = 1'b0;
  logic [3:0] row_in_n;
  logic [3:0] col_drive_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       overrun;
  logic [15:0] keys = '0;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    string      name;
    logic [15:0] keys;
    int         hold_sweeps;
    int         rel_sweeps;
    bit         exp_event;
    logic [3:0] exp_code;
    bit         exp_held;
  } vec_t;

  vec_t vecs[6];

  keypad_matrix_scanner #(
    .CLK_FREQ_HZ   (CLK_FREQ_HZ),
    .SCAN_FREQ_HZ  (SCAN_FREQ_HZ),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .col_drive_n(col_drive_n),
    .row_in_n   (row_in_n),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_held   (key_held),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Keypad contacts: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4 + c] && !col_drive_n[c]) row_in_n[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every handshake pops one expected code.
  always @(negedge clk) begin
    if (!rst && key_valid && key_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_event: got code %0d expected no event", key_code);
      end else begin
        logic [3:0] exp_code;
        exp_code = exp_q.pop_front();
        if (key_code !== exp_code) begin
          n_errors++;
          $display("FAIL event_code: got %0d expected %0d", key_code, exp_code);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"key9",        16'h0200, 6,  6, 1'b1, 4'd9,  1'b1};
    vecs[1] = '{"ghost_0_15",  16'h8001, 10, 6, 1'b0, 4'd0,  1'b0};
    vecs[2] = '{"key0",        16'h0001, 6,  6, 1'b1, 4'd0,  1'b1};
    vecs[3] = '{"key15",       16'h8000, 6,  6, 1'b1, 4'd15, 1'b1};
    vecs[4] = '{"same_row_45", 16'h0030, 6,  6, 1'b0, 4'd0,  1'b0};
    vecs[5] = '{"same_col_1_13", 16'h2002, 6, 6, 1'b0, 4'd0, 1'b0};

    // Reset and idle column scan.
    wait_cycles(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_col",     col_drive_n, 4'b1110);
    check("rst_code",    key_code,    4'd0);
    check("rst_valid",   key_valid,   1'b0);
    check("rst_held",    key_held,    1'b0);
    check("rst_overrun", overrun,     1'b0);
    for (int n = 0; n < 200; n++) begin
      logic [3:0] exp_col;
      @(posedge clk);
      @(negedge clk);
      exp_col = ~(4'b0001 << (((n + 1) / 16) % 4));
      check("scan_col", col_drive_n, exp_col);
    end
    check("idle_valid", key_valid, 1'b0);
    check("idle_held",  key_held,  1'b0);

    // Table-driven presses with key_ready held high.
    for (int i = 0; i < 6; i++) begin
      wait_cycles(1);
      key_ready = 1'b1;
      keys = vecs[i].keys;
      if (vecs[i].exp_event) exp_q.push_back(vecs[i].exp_code);
      wait_cycles(vecs[i].hold_sweeps * SWEEP);
      @(negedge clk);
      check({vecs[i].name, "_held"}, key_held, vecs[i].exp_held);
      check({vecs[i].name, "_consumed"}, exp_q.size(), 0);
      keys = '0;
      wait_cycles(SWEEP);
      check({vecs[i].name, "_held_after_release"}, key_held, vecs[i].exp_held);
      wait_cycles((vecs[i].rel_sweeps - 1) * SWEEP);
      @(negedge clk);
      check({vecs[i].name, "_released"}, key_held, 1'b0);
    end

    // Key 5 bouncing through the first sweep, then stable.
    exp_q.push_back(4'd5);
    for (int t = 0; t < 13; t++) begin
      keys[5] = ~keys[5];
      wait_cycles(5);
    end
    keys = 16'h0020;
    wait_cycles(6 * SWEEP);
    @(negedge clk);
    check("bounce_held", key_held, 1'b1);
    check("bounce_consumed", exp_q.size(), 0);
    keys = '0;
    wait_cycles(6 * SWEEP);
    @(negedge clk);
    check("bounce_released", key_held, 1'b0);

    // Overrun: two presses while the first event is unconsumed.
    wait_cycles(1);
    key_ready = 1'b0;
    exp_q.push_back(4'd3);
    keys = 16'h0008;
    wait_cycles(6 * SWEEP);
    keys = '0;
    wait_cycles(6 * SWEEP);
    @(negedge clk);
    check("ovr_first_valid",   key_valid, 1'b1);
    check("ovr_first_code",    key_code,  4'd3);
    check("ovr_first_overrun", overrun,   1'b0);
    keys = 16'h1000;
    wait_cycles(6 * SWEEP);
    keys = '0;
    wait_cycles(6 * SWEEP);
    @(negedge clk);
    check("ovr_code_kept", key_code,  4'd3);
    check("ovr_valid",     key_valid, 1'b1);
    check("ovr_sticky",    overrun,   1'b1);
    check("ovr_pending",   exp_q.size(), 1);
    wait_cycles(1);
    key_ready = 1'b1;
    wait_cycles(1);
    @(negedge clk);
    check("ovr_drained_valid", key_valid, 1'b0);
    check("ovr_drained_q",     exp_q.size(), 0);
    check("ovr_still_set",     overrun,   1'b1);

    // Reset during DEB_PRESS with an unconsumed event pending.
    wait_cycles(1);
    key_ready = 1'b0;
    keys = 16'h0400;
    wait_cycles(6 * SWEEP);
    keys = '0;
    wait_cycles(6 * SWEEP);
    @(negedge clk);
    check("pre_rst_valid", key_valid, 1'b1);
    check("pre_rst_code",  key_code,  4'd10);
    wait_cycles(1);
    keys = 16'h0040;
    wait_cycles(96);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    key_ready = 1'b1;
    exp_q.push_back(4'd6);
    @(negedge clk);
    check("mid_rst_col",     col_drive_n, 4'b1110);
    check("mid_rst_code",    key_code,    4'd0);
    check("mid_rst_valid",   key_valid,   1'b0);
    check("mid_rst_held",    key_held,    1'b0);
    check("mid_rst_overrun", overrun,     1'b0);
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 191) check("redeb_held_early", key_held, 1'b0);
      if (n == 192) begin
        check("redeb_held",        key_held,  1'b1);
        check("redeb_valid_early", key_valid, 1'b0);
      end
      if (n == 193) begin
        check("redeb_valid", key_valid, 1'b1);
        check("redeb_code",  key_code,  4'd6);
      end
    end
    keys = '0;
    wait_cycles(6 * SWEEP);
    @(negedge clk);
    check("final_consumed", exp_q.size(), 0);
    check("final_held",     key_held, 1'b0);
    check("final_overrun",  overrun,  1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Multiplexed-input counterpart of the display digit-scan logic: drives a 4x4 key matrix one column at a time and reads the row lines back.
- Debounces the scanned result and reports single key presses to the core as a 4-bit key code over a valid/ready handshake.
- Sits between the board keypad pins and the application logic. Typical consumer: the block feeding digits to the 7-segment display path.

Parameters:
- CLK_FREQ_HZ, 27000000, system clock frequency.
- SCAN_FREQ_HZ, 1000, column-advance rate. Column period DIV = CLK_FREQ_HZ/SCAN_FREQ_HZ cycles, integer; elaboration error if DIV < 4.
- DEBOUNCE_SCANS, 4, consecutive full sweeps needed to accept a press or a release. Range 1..15.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- col_drive_n, output, 4, column select, one-hot active-low.
- row_in_n, input, 4, raw row lines, active-low, asynchronous to clk (pull-ups on board).
- key_code, output, 4, accepted key = row*4 + col.
- key_valid, output, 1, key_code holds an unconsumed event.
- key_ready, input, 1, consumer accepts the event when key_valid && key_ready.
- key_held, output, 1, high while a debounced key is down.
- overrun, output, 1, sticky: a press was dropped because an earlier event was unconsumed.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). The whole block is in the clk domain.
- Reset values:
  - col_drive_n = 4'b1110 (column 0 active).
  - key_code = 0, key_valid = 0, key_held = 0, overrun = 0.
  - Divider count = 0, column index = 0, state = IDLE, debounce count = 0, sweep snapshot = 0.
- Reset asserted mid-operation discards any pending event and any debounce progress.
- Input sync: row_in_n passes through a 2-flop synchronizer, then is inverted to active-high rows.
- Divider: counts 0..DIV-1 and wraps.
  - On count == DIV-1, the synchronized rows are stored into 4 snapshot bits for the current column.
  - In the same cycle the column index advances (3 wraps to 0), and col_drive_n updates on the next edge.
- Sweep end: the sample of column 3 completes a sweep. The 16-bit snapshot is classified in the following cycle as:
  - NONE: zero bits set.
  - SINGLE(k): exactly one bit set, k = row*4 + col.
  - MULTI: two or more bits set. Treated as a ghosting hazard; never produces an event.
- State machine, evaluated once per sweep:
  - IDLE:
    - SINGLE(k) -> DEB_PRESS, candidate = k, count = 1.
    - NONE or MULTI -> stay.
  - DEB_PRESS:
    - SINGLE(candidate) -> count + 1.
    - SINGLE(other) -> candidate = other, count = 1.
    - NONE or MULTI -> IDLE.
    - When count reaches DEBOUNCE_SCANS -> PRESSED (DEBOUNCE_SCANS = 1 goes straight from IDLE to PRESSED).
  - PRESSED:
    - SINGLE(candidate), SINGLE(other) or MULTI -> stay. No new event until release.
    - NONE -> DEB_RELEASE, count = 1.
  - DEB_RELEASE:
    - NONE -> count + 1; count reaching DEBOUNCE_SCANS -> IDLE.
    - Any key seen -> PRESSED.
- key_held = 1 exactly while the state is PRESSED or DEB_RELEASE.
- Event on entry to PRESSED:
  - If key_valid = 0: the next cycle has key_code = candidate and key_valid = 1.
  - If key_valid = 1 and there is no handshake that cycle: the event is dropped, key_code is unchanged and overrun is set.
  - If a handshake occurs in the same cycle: the new event loads and no overrun occurs.
- Handshake:
  - key_valid stays high and key_code stays stable until a cycle with key_valid && key_ready. key_valid deasserts on the next edge.
  - key_ready while key_valid = 0 is ignored.
- overrun clears only on rst.
- Press latency: from the first sweep containing the key, the event appears DEBOUNCE_SCANS sweeps later plus 2 cycles (classify, then load). A sweep is 4*DIV cycles.

Test Plan:
(Test parameters: CLK_FREQ_HZ=64, SCAN_FREQ_HZ=4 (DIV=16), DEBOUNCE_SCANS=3.)
- Reset, then idle 200 cycles -> col_drive_n cycles through 1110, 1101, 1011, 0111, changing every 16 cycles; key_valid = 0; key_held = 0.
- Hold key row 2/col 1 (model pulls row_in_n[2] low while col_drive_n[1] = 0), key_ready = 1 -> key_valid pulses once with key_code = 9; key_held = 1 until 3 clean sweeps after release.
- Press key 5 with bounce (toggle every 5 cycles) during the first sweep, then hold it stable -> exactly one event, code 5, with no spurious codes.
- Hold keys 0 and 15 together for 10 sweeps -> no event; key_held = 0.
- key_ready = 0; press and release key 3, then press and release key 12 -> key_code = 3 stays valid, overrun = 1; raise key_ready -> one handshake, then key_valid = 0.
- Assert rst while in DEB_PRESS with key_valid = 1 -> all outputs return to reset values the next cycle; the key still held re-debounces from count 1.
